// File: rtl/sevenseg_pkg.sv
// Shared types and the hex-to-segment table for the 7-segment scan controller.
// Segment vectors are {g,f,e,d,c,b,a} with bit 0 = a, active-high (1 = lit).
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_OFF = 7'h00;

  // Entry n is the glyph for nibble n; entry 15 is the leftmost literal.
  localparam logic [15:0][6:0] HEX_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_TABLE[nibble];
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational digit decoder: hex nibble to segment glyph plus decimal point.
// Ports:
//   nibble_i  hex value of the digit being shown
//   dark_i    1 = digit is dark (disabled or blanked); forces segments and dp off
//   dp_req_i  decimal point request for this digit
//   seg_o     active-high segments {g,f,e,d,c,b,a}
//   dp_o      active-high decimal point
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dark_i,
  input  logic       dp_req_i,
  output seg_t       seg_o,
  output logic       dp_o
);

  always_comb begin
    seg_o = hex_to_seg(nibble_i);
    dp_o  = dp_req_i;
    if (dark_i) begin
      seg_o = SEG_OFF;
      dp_o  = 1'b0;
    end
  end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed driver for N_DIGITS 7-segment digits.
// Each digit owns a slot of REFRESH_DIV clocks; the first clock of a slot is anode dead
// time. New values are double-buffered and only become visible at a frame boundary.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   load_i       strobe capturing value_i/dp_i/digit_en_i
//   value_i      hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_i         decimal point request per digit
//   digit_en_i   per-digit enable (0 = dark)
//   blank_lz_i   leading-zero blanking enable, applied live
//   seg_o, dp_o  segment pins {g..a} and decimal point, polarity set by ACTIVE_LOW
//   an_o         digit select pins, one-hot when active
//   frame_o      one-cycle pulse at the start of each scan frame
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int unsigned N_DIGITS    = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic [4*N_DIGITS-1:0]   value_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic [N_DIGITS-1:0]     digit_en_i,
  input  logic                    blank_lz_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [N_DIGITS-1:0]     an_o,
  output logic                    frame_o
);

  localparam int unsigned IdxW   = $clog2(N_DIGITS);
  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(N_DIGITS - 1);
  localparam logic [PrescW-1:0] PrescLast = PrescW'(REFRESH_DIV - 1);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [N_DIGITS-1:0][3:0] act_val_q, act_val_d, pend_val_q, pend_val_d;
  logic [N_DIGITS-1:0]      act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]      act_en_q, act_en_d, pend_en_q, pend_en_d;
  logic                     pend_valid_q, pend_valid_d;

  logic [6:0]          seg_q;
  logic                dp_q;
  logic [N_DIGITS-1:0] an_q;
  logic                frame_q;

  logic                slot_end, frame_wrap;
  logic [N_DIGITS-1:0] lz_blank;
  logic                nz_seen;
  logic                dark;
  seg_t                seg_int;
  logic                dp_int;
  logic [N_DIGITS-1:0] an_int;

  // Scan position
  assign slot_end   = (presc_q == PrescLast);
  assign frame_wrap = slot_end && (idx_q == IdxLast);

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + PrescW'(1);
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  // Double buffer: a load on the wrap cycle goes straight to the active copy so it is
  // shown in the frame that is about to start.
  always_comb begin
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    if (frame_wrap) begin
      if (load_i) begin
        act_val_d    = value_i;
        act_dp_d     = dp_i;
        act_en_d     = digit_en_i;
        pend_valid_d = 1'b0;
      end else if (pend_valid_q) begin
        act_val_d    = pend_val_q;
        act_dp_d     = pend_dp_q;
        act_en_d     = pend_en_q;
        pend_valid_d = 1'b0;
      end
    end else if (load_i) begin
      pend_val_d   = value_i;
      pend_dp_d    = dp_i;
      pend_en_d    = digit_en_i;
      pend_valid_d = 1'b1;
    end
  end

  // Leading-zero map: running OR from the most significant digit down; digit 0 never blanks.
  always_comb begin
    lz_blank = '0;
    nz_seen  = 1'b0;
    for (int k = int'(N_DIGITS) - 1; k >= 0; k--) begin
      nz_seen     = nz_seen | (|act_val_q[k]);
      lz_blank[k] = ~nz_seen;
    end
    lz_blank[0] = 1'b0;
  end

  assign dark = ~act_en_q[idx_q] | (blank_lz_i & lz_blank[idx_q]);

  sevenseg_decode u_decode (
    .nibble_i (act_val_q[idx_q]),
    .dark_i   (dark),
    .dp_req_i (act_dp_q[idx_q]),
    .seg_o    (seg_int),
    .dp_o     (dp_int)
  );

  // Anodes stay off for the first clock of each slot to avoid ghosting.
  always_comb begin
    an_int = '0;
    if (presc_q != '0) begin
      an_int[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= SEG_OFF ^ {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      an_q         <= {N_DIGITS{ACTIVE_LOW}};
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_int ^ {7{ACTIVE_LOW}};
      dp_q         <= dp_int ^ ACTIVE_LOW;
      an_q         <= an_int ^ {N_DIGITS{ACTIVE_LOW}};
      frame_q      <= frame_wrap;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign an_o    = an_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Bench for sevenseg_scan_ctrl: an active-low and an active-high instance share stimulus
// and are compared every cycle against a time-indexed reference model.
module tb_sevenseg_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned DIV   = 4;
  localparam int unsigned FRAME = ND * DIV;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load_i, blank_lz_i;
  logic [15:0] value_i;
  logic [3:0]  dp_i, digit_en_i;

  logic [6:0] seg_lo, seg_hi;
  logic       dp_lo, dp_hi, frame_lo, frame_hi;
  logic [3:0] an_lo, an_hi;

  sevenseg_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .digit_en_i (digit_en_i),
    .blank_lz_i (blank_lz_i),
    .seg_o      (seg_lo),
    .dp_o       (dp_lo),
    .an_o       (an_lo),
    .frame_o    (frame_lo)
  );

  sevenseg_scan_ctrl #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_i),
    .value_i    (value_i),
    .dp_i       (dp_i),
    .digit_en_i (digit_en_i),
    .blank_lz_i (blank_lz_i),
    .seg_o      (seg_hi),
    .dp_o       (dp_hi),
    .an_o       (an_hi),
    .frame_o    (frame_hi)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: t = clocks since reset release, buffers as plain words.
  int          t;
  logic [15:0] m_val, m_pval;
  logic [3:0]  m_dp, m_en, m_pdp, m_pen;
  bit          m_pv;
  logic [6:0]  e_seg;
  logic        e_dp, e_frame;
  logic [3:0]  e_an;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_hex(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic model_edge();
    int  slot, phase;
    bit  zeros, dark, boundary;
    if (rst) begin
      t = 0;
      m_val = '0; m_pval = '0; m_dp = '0; m_en = '0; m_pdp = '0; m_pen = '0; m_pv = 0;
      e_seg = '0; e_dp = 1'b0; e_an = '0; e_frame = 1'b0;
      return;
    end
    slot  = (t / DIV) % ND;
    phase = t % DIV;
    zeros = 1;
    for (int k = slot; k < ND; k++) if (m_val[4*k +: 4] != 4'h0) zeros = 0;
    dark     = !m_en[slot] || (blank_lz_i && slot != 0 && zeros);
    e_seg    = dark ? 7'h00 : ref_hex(m_val[4*slot +: 4]);
    e_dp     = dark ? 1'b0 : m_dp[slot];
    e_an     = (phase == 0) ? 4'h0 : 4'(1 << slot);
    boundary = (t % FRAME) == FRAME - 1;
    e_frame  = boundary;
    if (boundary) begin
      if (load_i) begin
        m_val = value_i; m_dp = dp_i; m_en = digit_en_i; m_pv = 0;
      end else if (m_pv) begin
        m_val = m_pval; m_dp = m_pdp; m_en = m_pen; m_pv = 0;
      end
    end else if (load_i) begin
      m_pval = value_i; m_pdp = dp_i; m_pen = digit_en_i; m_pv = 1;
    end
    t++;
  endtask

  task automatic tick();
    logic [6:0] p_seg;
    logic [3:0] p_an;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    p_seg = ~e_seg;
    p_an  = ~e_an;
    check_eq("seg_hi", 32'(seg_hi), 32'(e_seg));
    check_eq("dp_hi", 32'(dp_hi), 32'(e_dp));
    check_eq("an_hi", 32'(an_hi), 32'(e_an));
    check_eq("frame_hi", 32'(frame_hi), 32'(e_frame));
    check_eq("seg_lo", 32'(seg_lo), 32'(p_seg));
    check_eq("dp_lo", 32'(dp_lo), 32'(!e_dp));
    check_eq("an_lo", 32'(an_lo), 32'(p_an));
    check_eq("frame_lo", 32'(frame_lo), 32'(e_frame));
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] en);
    value_i = v; dp_i = dp; digit_en_i = en; load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  // Bounded wait for a frame pulse on the active-low instance.
  task automatic wait_frame(input string tag);
    bit seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      tick();
      seen = frame_lo;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  // After a frame pulse: check the active-low glyph shown in each digit slot.
  task automatic check_frame(input string tag, input logic [6:0] d0, input logic [6:0] d1,
                             input logic [6:0] d2, input logic [6:0] d3);
    logic [6:0] exp [4];
    exp = '{d0, d1, d2, d3};
    wait_frame({tag, "_frame"});
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq(tag, 32'(seg_lo), 32'(exp[k]));
      repeat (DIV - 1) tick();
    end
  endtask

  task automatic goto_pos(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1; load_i = 1'b0; blank_lz_i = 1'b0;
    value_i = '0; dp_i = '0; digit_en_i = '0;
    t = 0;

    // 1: reset values, then first-frame latency
    repeat (3) tick();
    check_eq("rst_seg", 32'(seg_lo), 32'h7F);
    check_eq("rst_dp", 32'(dp_lo), 32'h1);
    check_eq("rst_an", 32'(an_lo), 32'hF);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 3 * FRAME && lat == 0; i++) begin
      tick();
      if (frame_lo) lat = i;
    end
    check_eq("frame_latency", 32'(lat), 32'd16);

    // 2: mid-frame load only appears after the next boundary
    repeat (5) tick();
    do_load(16'h12AF, 4'h0, 4'hF);
    check_frame("hex_12af", 7'h0E, 7'h08, 7'h24, 7'h79);

    // 3: last pending load wins; load on the wrap cycle shows in that frame
    repeat (3) tick();
    do_load(16'h1111, 4'h0, 4'hF);
    repeat (2) tick();
    do_load(16'h2222, 4'h0, 4'hF);
    check_frame("last_wins", 7'h24, 7'h24, 7'h24, 7'h24);
    goto_pos(FRAME - 1);
    do_load(16'h5A3C, 4'h0, 4'hF);
    check_eq("bnd_frame", 32'(frame_lo), 32'd1);
    tick();
    check_eq("bnd_dig0", 32'(seg_lo), 32'h46);
    repeat (2 * FRAME) tick();

    // 4: leading-zero blanking, dp suppressed on a blanked digit
    blank_lz_i = 1'b1;
    do_load(16'h0070, 4'b1000, 4'hF);
    check_frame("lz_0070", 7'h40, 7'h78, 7'h7F, 7'h7F);
    do_load(16'h0000, 4'b0000, 4'hF);
    check_frame("lz_0000", 7'h40, 7'h7F, 7'h7F, 7'h7F);
    blank_lz_i = 1'b0;

    // 5: disabled digits still get their anode slot but stay dark
    do_load(16'h8888, 4'h0, 4'b0101);
    check_frame("en_0101", 7'h00, 7'h7F, 7'h00, 7'h7F);

    // 6: reset mid-slot at idx 2
    goto_pos(2 * DIV + 1);
    rst = 1'b1;
    tick();
    check_eq("rst_mid_seg_lo", 32'(seg_lo), 32'h7F);
    check_eq("rst_mid_an_lo", 32'(an_lo), 32'hF);
    check_eq("rst_mid_seg_hi", 32'(seg_hi), 32'h00);
    check_eq("rst_mid_an_hi", 32'(an_hi), 32'h0);
    rst = 1'b0;
    repeat (2 * FRAME) tick();

    // Randomized traffic, including wrap-cycle loads and occasional resets
    for (int i = 0; i < 1500; i++) begin
      load_i     = ($urandom_range(0, 11) == 0) ||
                   ((t % FRAME) == FRAME - 1 && $urandom_range(0, 1) == 1);
      value_i    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_i       = 4'($urandom);
      digit_en_i = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 31) == 0) blank_lz_i = ~blank_lz_i;
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end
    load_i = 1'b0; rst = 1'b0;
    repeat (FRAME) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
